escalonador_tx: RTL and testbench

Round-robin scheduler that shares one serial frame transmitter (start bit, 4-bit dado, 4-bit instrucao, stop bit) among N_REQ requesters. It sits between the requesting blocks and the transmitter. It arbitrates pending requests and latches the winner's payload onto the transmitter inputs. It then pulses the start strobe and tracks the transmitter's busy flag until the frame completes. It owns no serializer logic itself.

---
 rtl/escalonador_tx.sv | 134 +++++++++++++
 tb/tb_escalonador_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_tx.sv
// escalonador_tx: round-robin scheduler that shares one serial frame transmitter among N_REQ requesters.
// Define ESCALONADOR_TIMEOUT_EN to abort ACEITE after TIMEOUT cycles and raise the sticky erro flag.
module escalonador_tx #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   dado_in,
  input  logic [4*N_REQ-1:0]   instrucao_in,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [3:0]           tx_dado,
  output logic [3:0]           tx_instrucao,
  input  logic                 tx_ocupado,
  output logic [IDW-1:0]       grant,
  output logic                 ativo,
  output logic                 erro
);

  typedef enum logic [1:0] {
    OCIOSO,
    ACEITE,
    TRANSMITE
  } estado_t;

  localparam logic [IDW-1:0] ULTIMO_RST = IDW'(N_REQ - 1);
  localparam int             IDW_OK     = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

  // Reject illegal parameterisations at elaboration time.
  if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
    $error("escalonador_tx: N_REQ must be within 2..8");
  end
  if (IDW != IDW_OK) begin : g_chk_idw
    $error("escalonador_tx: IDW must equal max(1, clog2(N_REQ))");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("escalonador_tx: TIMEOUT must be at least 1");
  end

  estado_t        estado;
  logic [IDW-1:0] ultimo;
  logic [IDW-1:0] vencedor;
  logic           tem_vencedor;
  int             idx;

`ifdef ESCALONADOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign erro = 1'b0;
`endif

  // Round-robin pick: first asserted req scanning upward from the one after the last winner.
  always_comb begin
    vencedor     = '0;
    tem_vencedor = 1'b0;
    idx          = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ultimo) + k) % N_REQ;
      if (!tem_vencedor && req[idx]) begin
        vencedor     = IDW'(idx);
        tem_vencedor = 1'b1;
      end
    end
  end

  // ACEITE ignores tx_ocupado while tx_start is still high, so a busy flag left over from
  // a foreign frame cannot be mistaken for the acknowledgement of ours.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      ack          <= '0;
      tx_start     <= 1'b0;
      tx_dado      <= 4'h0;
      tx_instrucao <= 4'h0;
      grant        <= '0;
      ativo        <= 1'b0;
      ultimo       <= ULTIMO_RST;
`ifdef ESCALONADOR_TIMEOUT_EN
      cnt          <= '0;
      erro         <= 1'b0;
`endif
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (tem_vencedor && !tx_ocupado) begin
            tx_dado      <= dado_in[{vencedor, 2'b00} +: 4];
            tx_instrucao <= instrucao_in[{vencedor, 2'b00} +: 4];
            grant        <= vencedor;
            ack          <= N_REQ'(1) << vencedor;
            tx_start     <= 1'b1;
            ativo        <= 1'b1;
            estado       <= ACEITE;
`ifdef ESCALONADOR_TIMEOUT_EN
            cnt          <= '0;
`endif
          end
        end
        ACEITE: begin
          if (!tx_start && tx_ocupado) begin
            estado <= TRANSMITE;
          end
`ifdef ESCALONADOR_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            erro   <= 1'b1;
            ultimo <= grant;
            ativo  <= 1'b0;
            estado <= OCIOSO;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        TRANSMITE: begin
          if (!tx_ocupado) begin
            ultimo <= grant;
            ativo  <= 1'b0;
            estado <= OCIOSO;
          end
        end
        default: begin
          ativo  <= 1'b0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_tx.sv
// tb_escalonador_tx: directed checks of escalonador_tx with a small transmitter model.
// The timeout scenario runs only when ESCALONADOR_TIMEOUT_EN is defined.
module tb_escalonador_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] dado_in;
  logic [15:0] instrucao_in;
  logic [3:0]  ack;
  logic        tx_start;
  logic [3:0]  tx_dado;
  logic [3:0]  tx_instrucao;
  logic        tx_ocupado;
  logic [1:0]  grant;
  logic        ativo;
  logic        erro;

  int tests  = 0;
  int failed = 0;

  logic       autoDrop  = 1'b0;
  logic       txForce   = 1'b0;
  logic       txEnable  = 1'b1;
  logic [4:0] busyCnt   = '0;
  int         grants[8];
  int         nStarts;
  int         acksSeen;
  int         ackViolations;

  escalonador_tx #(.N_REQ(4), .IDW(2), .TIMEOUT(16)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .dado_in(dado_in),
    .instrucao_in(instrucao_in),
    .ack(ack),
    .tx_start(tx_start),
    .tx_dado(tx_dado),
    .tx_instrucao(tx_instrucao),
    .tx_ocupado(tx_ocupado),
    .grant(grant),
    .ativo(ativo),
    .erro(erro)
  );

  always #5 clock = ~clock;

  // Transmitter model: busy for 10 cycles starting the cycle after it samples tx_start.
  always @(posedge clock) begin
    if (tx_start && txEnable) busyCnt <= 5'd10;
    else if (busyCnt != 0) busyCnt <= busyCnt - 5'd1;
  end
  assign tx_ocupado = txForce | (busyCnt != 0);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
    if (autoDrop) req = req & ~ack;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic watch(input int budget);
    logic [3:0] prevAck;
    prevAck       = '0;
    nStarts       = 0;
    acksSeen      = 0;
    ackViolations = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (tx_start) begin
        if (nStarts < 8) grants[nStarts] = int'(grant);
        nStarts++;
        if (ack !== (4'b0001 << grant)) ackViolations++;
      end
      if (ack != 0) acksSeen++;
      if ($countones(ack) > 1 || (prevAck != 0 && ack != 0)) ackViolations++;
      prevAck = ack;
    end
  endtask

  task automatic waitIdle(input string tag);
    int w;
    w = 0;
    while ((ativo || tx_ocupado) && w < 60) begin
      tick();
      w++;
    end
    checkOutput(tag, {31'd0, ativo | tx_ocupado}, 32'd0);
  endtask

  initial begin
    int w;
    reset        = 1'b1;
    req          = 4'b0000;
    dado_in      = 16'hDCBA;
    instrucao_in = 16'h8765;

    applyReset();
    checkOutput("reset ack", ack, 0);
    checkOutput("reset tx_start", tx_start, 0);
    checkOutput("reset tx_dado", tx_dado, 0);
    checkOutput("reset tx_instrucao", tx_instrucao, 0);
    checkOutput("reset grant", grant, 0);
    checkOutput("reset ativo", ativo, 0);
    checkOutput("reset erro", erro, 0);

    // Single requester 0, full frame.
    autoDrop = 1'b1;
    applyStimulus(4'b0001);
    tick();
    checkOutput("t1 ack", ack, 4'b0001);
    checkOutput("t1 tx_start", tx_start, 1);
    checkOutput("t1 tx_dado", tx_dado, 4'hA);
    checkOutput("t1 tx_instrucao", tx_instrucao, 4'h5);
    checkOutput("t1 grant", grant, 0);
    checkOutput("t1 ativo", ativo, 1);
    tick();
    checkOutput("t1 strobe drop", {ack, tx_start}, 0);
    w = 0;
    while (tx_ocupado && w < 30) begin
      tick();
      w++;
    end
    checkOutput("t1 busy cycles", w, 10);
    checkOutput("t1 ativo at release", ativo, 1);
    tick();
    checkOutput("t1 ativo after release", ativo, 0);
    checkOutput("t1 tx_dado hold", tx_dado, 4'hA);

    // All four requesting, each dropping on ack.
    applyReset();
    applyStimulus(4'b1111);
    watch(70);
    checkOutput("t2 starts", nStarts, 4);
    checkOutput("t2 grant0", grants[0], 0);
    checkOutput("t2 grant1", grants[1], 1);
    checkOutput("t2 grant2", grants[2], 2);
    checkOutput("t2 grant3", grants[3], 3);
    checkOutput("t2 ack overlap", ackViolations, 0);
    checkOutput("t2 req drained", req, 0);

    // Requesters 0 and 2 never drop their req.
    applyReset();
    autoDrop = 1'b0;
    applyStimulus(4'b0101);
    watch(54);
    checkOutput("t3 grant0", grants[0], 0);
    checkOutput("t3 grant1", grants[1], 2);
    checkOutput("t3 grant2", grants[2], 0);
    checkOutput("t3 grant3", grants[3], 2);
    checkOutput("t3 ack violations", ackViolations, 0);
    applyStimulus(4'b0000);
    waitIdle("t3 idle");

    // Foreign busy blocks arbitration.
    applyReset();
    autoDrop = 1'b1;
    txForce  = 1'b1;
    applyStimulus(4'b0010);
    watch(6);
    checkOutput("t4 no start while busy", nStarts, 0);
    checkOutput("t4 no ack while busy", acksSeen, 0);
    txForce = 1'b0;
    tick();
    checkOutput("t4 tx_start", tx_start, 1);
    checkOutput("t4 ack", ack, 4'b0010);
    checkOutput("t4 grant", grant, 1);
    checkOutput("t4 tx_dado", tx_dado, 4'hB);

    // Reset while the frame is in TRANSMITE.
    tick();
    tick();
    tick();
    checkOutput("t5 ativo before reset", ativo, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5 ativo after reset", ativo, 0);
    checkOutput("t5 grant after reset", grant, 0);
    checkOutput("t5 tx_dado after reset", tx_dado, 0);
    applyStimulus(4'b0100);
    w = 0;
    while (!tx_start && w < 30) begin
      tick();
      w++;
    end
    checkOutput("t5 wait for release", w, 8);
    checkOutput("t5 grant", grant, 2);
    checkOutput("t5 ack", ack, 4'b0100);
    checkOutput("t5 tx_instrucao", tx_instrucao, 4'h7);
    waitIdle("t5 idle");

`ifdef ESCALONADOR_TIMEOUT_EN
    // Transmitter never answers: timeout drops the frame.
    applyReset();
    txEnable = 1'b0;
    applyStimulus(4'b0001);
    tick();
    checkOutput("t6 tx_start", tx_start, 1);
    applyStimulus(4'b1000);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("t6 erro before timeout", erro, 0);
    checkOutput("t6 ativo before timeout", ativo, 1);
    tick();
    checkOutput("t6 erro at timeout", erro, 1);
    checkOutput("t6 ativo at timeout", ativo, 0);
    txEnable = 1'b1;
    tick();
    checkOutput("t6 pending start", tx_start, 1);
    checkOutput("t6 pending grant", grant, 3);
    waitIdle("t6 idle");
    checkOutput("t6 erro sticky", erro, 1);
    applyReset();
    checkOutput("t6 erro cleared", erro, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
